// File: rtl/adder_share_arbiter.sv
// adder_share_arbiter
// Shares one external combinational 32-bit adder among NUM_REQ requesters.
// Requests are granted round-robin, the winner's operands are latched and
// driven to the adder, and the registered sum is returned together with
// the requester index on a valid/ready response channel. Only one
// transaction is in flight at a time.
//
// Optional feature: define ADDER_ARB_OVF_EN to add the rsp_ovf output,
// a signed-overflow flag captured together with the sum.

`timescale 1ns/1ps

module adder_share_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [32*NUM_REQ-1:0]   req_a,
  input  logic [32*NUM_REQ-1:0]   req_b,
  output logic [31:0]             add_in1,
  output logic [31:0]             add_in2,
  input  logic [31:0]             add_sum,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [ID_W-1:0]         rsp_id,
  output logic [31:0]             rsp_sum
`ifdef ADDER_ARB_OVF_EN
  ,
  output logic                    rsp_ovf
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t            state;
  state_t            state_next;
  logic [ID_W-1:0]   last_grant;
  logic [ID_W-1:0]   grant_idx;
  logic              grant_found;
  logic [ID_W-1:0]   cur_id;
  logic [31:0]       sel_a;
  logic [31:0]       sel_b;
  logic              accept;

  // Round-robin pick: first valid requester above last_grant, else wrap to the lowest
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!grant_found && req_valid[i] && (i > int'(last_grant))) begin
        grant_found = 1'b1;
        grant_idx   = ID_W'(i);
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!grant_found && req_valid[i] && (i <= int'(last_grant))) begin
        grant_found = 1'b1;
        grant_idx   = ID_W'(i);
      end
    end
  end

  // Operand mux selecting the winning requester's slice of the packed buses
  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_idx == ID_W'(i)) begin
        sel_a = req_a[32*i +: 32];
        sel_b = req_b[32*i +: 32];
      end
    end
  end

  assign accept = (state == IDLE) && grant_found;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic and the one-hot accept strobe, which stays low while reset is held
  always_comb begin
    state_next = state;
    req_ready  = '0;
    case (state)
      IDLE: begin
        if (grant_found) begin
          state_next = EXEC;
          for (int i = 0; i < NUM_REQ; i++) begin
            if (rst_n && (grant_idx == ID_W'(i))) begin
              req_ready[i] = 1'b1;
            end
          end
        end
      end
      EXEC: begin
        state_next = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Datapath: operand latch doubles as adder drive (held between transactions), result capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      add_in1    <= '0;
      add_in2    <= '0;
      cur_id     <= '0;
      last_grant <= ID_W'(NUM_REQ - 1);
      rsp_valid  <= 1'b0;
      rsp_id     <= '0;
      rsp_sum    <= '0;
`ifdef ADDER_ARB_OVF_EN
      rsp_ovf    <= 1'b0;
`endif
    end else begin
      if (accept) begin
        add_in1    <= sel_a;
        add_in2    <= sel_b;
        cur_id     <= grant_idx;
        last_grant <= grant_idx;
      end
      if (state == EXEC) begin
        rsp_sum   <= add_sum;
        rsp_id    <= cur_id;
        rsp_valid <= 1'b1;
`ifdef ADDER_ARB_OVF_EN
        rsp_ovf   <= (add_in1[31] == add_in2[31]) && (add_sum[31] != add_in1[31]);
`endif
      end
      if ((state == RESP) && rsp_ready) begin
        rsp_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_adder_share_arbiter.sv
// tb_adder_share_arbiter
// Self-checking bench for adder_share_arbiter. The external adder is
// modelled as a plain 32-bit addition. Expected grants come from a
// round-robin reference (rotate-and-search from the last grant) and
// expected results from plain arithmetic on the granted operands.

`timescale 1ns/1ps

module tb_adder_share_arbiter;

  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b1;
  logic [NUM_REQ-1:0]    req_valid = '0;
  logic [NUM_REQ-1:0]    req_ready;
  logic [32*NUM_REQ-1:0] req_a;
  logic [32*NUM_REQ-1:0] req_b;
  logic [31:0]           add_in1;
  logic [31:0]           add_in2;
  logic [31:0]           add_sum;
  logic                  rsp_valid;
  logic                  rsp_ready = 1'b0;
  logic [ID_W-1:0]       rsp_id;
  logic [31:0]           rsp_sum;
`ifdef ADDER_ARB_OVF_EN
  logic                  rsp_ovf;
`endif

  logic [31:0] op_a [NUM_REQ];
  logic [31:0] op_b [NUM_REQ];

  int checks = 0;
  int errors = 0;
  int m_last = NUM_REQ - 1;

  typedef struct {
    int          id;
    logic [31:0] sum;
    logic        ovf;
  } exp_t;

  always #5 clk = ~clk;

  assign add_sum = add_in1 + add_in2;

  always_comb begin
    req_a = '0;
    req_b = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_a[32*i +: 32] = op_a[i[ID_W-1:0]];
      req_b[32*i +: 32] = op_b[i[ID_W-1:0]];
    end
  end

  adder_share_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .add_in1   (add_in1),
    .add_in2   (add_in2),
    .add_sum   (add_sum),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_sum   (rsp_sum)
`ifdef ADDER_ARB_OVF_EN
    ,
    .rsp_ovf   (rsp_ovf)
`endif
  );

  // Reference round-robin: scan the requesters in rotated order starting after the last grant
  function automatic int model_pick(input logic [NUM_REQ-1:0] mask);
    int idx;
    for (int off = 1; off <= NUM_REQ; off++) begin
      idx = (m_last + off) % NUM_REQ;
      if (mask[idx[ID_W-1:0]]) return idx;
    end
    return -1;
  endfunction

  function automatic logic [NUM_REQ-1:0] onehot(input int g);
    logic [NUM_REQ-1:0] v;
    v = '0;
    if (g >= 0) v[g[ID_W-1:0]] = 1'b1;
    return v;
  endfunction

  // Signed overflow from wide signed arithmetic rather than sign-bit rules
  function automatic logic model_ovf(input logic [31:0] a, input logic [31:0] b);
    longint s;
    longint lim;
    lim = 64'sd2147483647;
    s = longint'($signed(a)) + longint'($signed(b));
    return (s > lim) || (s < -lim - 1);
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst_n     = 1'b0;
    req_valid = '0;
    rsp_ready = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      op_a[i[ID_W-1:0]] = '0;
      op_b[i[ID_W-1:0]] = '0;
    end
    repeat (2) @(posedge clk);
    #1;
    rst_n  = 1'b1;
    m_last = NUM_REQ - 1;
    #1;
  endtask

  task automatic test_reset;
    req_valid = '1;
    for (int i = 0; i < NUM_REQ; i++) begin
      op_a[i[ID_W-1:0]] = $urandom;
      op_b[i[ID_W-1:0]] = $urandom;
    end
    #2 rst_n = 1'b0;
    #2;
    checks++;
    if (req_ready !== '0) begin
      errors++;
      $display("[TB] FAIL reset_req_ready: got %b expected 0", req_ready);
    end
    checks++;
    if (add_in1 !== 32'h0 || add_in2 !== 32'h0) begin
      errors++;
      $display("[TB] FAIL reset_add_in: got %h/%h expected 0/0", add_in1, add_in2);
    end
    checks++;
    if (rsp_valid !== 1'b0 || rsp_id !== '0 || rsp_sum !== 32'h0) begin
      errors++;
      $display("[TB] FAIL reset_rsp: got v=%b id=%0d sum=%h expected 0/0/0", rsp_valid, rsp_id, rsp_sum);
    end
`ifdef ADDER_ARB_OVF_EN
    checks++;
    if (rsp_ovf !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_ovf: got %b expected 0", rsp_ovf);
    end
`endif
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (req_ready !== '0 || rsp_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_held: got ready=%b valid=%b expected 0/0", req_ready, rsp_valid);
    end
  endtask

  task automatic test_single;
    do_reset();
    rsp_ready = 1'b1;
    op_a[0] = 32'h0000_0005;
    op_b[0] = 32'h0000_0003;
    req_valid = 4'b0001;
    #1;
    checks++;
    if (req_ready !== 4'b0001) begin
      errors++;
      $display("[TB] FAIL single_accept: got %b expected 0001", req_ready);
    end
    m_last = 0;
    tick();
    req_valid = '0;
    #1;
    checks++;
    if (rsp_valid !== 1'b0 || add_in1 !== 32'h5 || add_in2 !== 32'h3) begin
      errors++;
      $display("[TB] FAIL single_exec: got v=%b in1=%h in2=%h expected 0/5/3", rsp_valid, add_in1, add_in2);
    end
    tick();
    checks++;
    if (rsp_valid !== 1'b1 || rsp_sum !== 32'h8 || rsp_id !== 2'd0) begin
      errors++;
      $display("[TB] FAIL single_rsp: got v=%b sum=%h id=%0d expected 1/8/0", rsp_valid, rsp_sum, rsp_id);
    end
    tick();
    checks++;
    if (rsp_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL single_drop: got %b expected 0", rsp_valid);
    end
  endtask

  task automatic test_wrap;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] e;
    for (int k = 0; k < 2; k++) begin
      a = (k == 0) ? 32'hFFFF_FFFF : 32'h7FFF_FFFF;
      b = 32'h0000_0001;
      e = (k == 0) ? 32'h0000_0000 : 32'h8000_0000;
      op_a[0] = a;
      op_b[0] = b;
      req_valid = 4'b0001;
      #1;
      checks++;
      if (req_ready !== 4'b0001) begin
        errors++;
        $display("[TB] FAIL wrap_accept: got %b expected 0001", req_ready);
      end
      m_last = 0;
      tick();
      req_valid = '0;
      tick();
      checks++;
      if (rsp_valid !== 1'b1 || rsp_sum !== e) begin
        errors++;
        $display("[TB] FAIL wrap_sum: got v=%b sum=%h expected 1/%h", rsp_valid, rsp_sum, e);
      end
`ifdef ADDER_ARB_OVF_EN
      checks++;
      if (rsp_ovf !== model_ovf(a, b)) begin
        errors++;
        $display("[TB] FAIL wrap_ovf: got %b expected %b", rsp_ovf, model_ovf(a, b));
      end
`endif
      tick();
    end
  endtask

  task automatic test_round_robin;
    int seq [5] = '{0, 1, 2, 3, 0};
    int g;
    logic [31:0] e;
    do_reset();
    for (int i = 0; i < NUM_REQ; i++) begin
      op_a[i[ID_W-1:0]] = $urandom;
      op_b[i[ID_W-1:0]] = 32'(i);
    end
    req_valid = '1;
    rsp_ready = 1'b1;
    #1;
    for (int t = 0; t < 5; t++) begin
      g = seq[t];
      e = op_a[g[ID_W-1:0]] + op_b[g[ID_W-1:0]];
      checks++;
      if (req_ready !== onehot(g)) begin
        errors++;
        $display("[TB] FAIL rr_grant%0d: got %b expected %b", t, req_ready, onehot(g));
      end
      m_last = g;
      tick();
      tick();
      checks++;
      if (rsp_valid !== 1'b1 || int'(rsp_id) != g || rsp_sum !== e) begin
        errors++;
        $display("[TB] FAIL rr_rsp%0d: got v=%b id=%0d sum=%h expected 1/%0d/%h", t, rsp_valid, rsp_id, rsp_sum, g, e);
      end
      tick();
    end
    req_valid = '0;
    #1;
  endtask

  task automatic test_backpressure;
    logic [31:0] e;
    op_a[1] = $urandom;
    op_b[1] = $urandom;
    op_a[2] = $urandom;
    op_b[2] = $urandom;
    e = op_a[1] + op_b[1];
    rsp_ready = 1'b0;
    req_valid = 4'b0010;
    #1;
    checks++;
    if (req_ready !== onehot(model_pick(req_valid))) begin
      errors++;
      $display("[TB] FAIL bp_accept: got %b expected %b", req_ready, onehot(model_pick(req_valid)));
    end
    m_last = 1;
    tick();
    req_valid = 4'b0100;
    tick();
    for (int c = 0; c < 5; c++) begin
      checks++;
      if (rsp_valid !== 1'b1 || rsp_sum !== e || rsp_id !== 2'd1 || req_ready !== '0) begin
        errors++;
        $display("[TB] FAIL bp_hold%0d: got v=%b sum=%h id=%0d ready=%b expected 1/%h/1/0000", c, rsp_valid, rsp_sum, rsp_id, req_ready, e);
      end
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    checks++;
    if (req_ready !== 4'b0100 || rsp_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL bp_next_grant: got ready=%b v=%b expected 0100/0", req_ready, rsp_valid);
    end
    m_last = 2;
    tick();
    req_valid = '0;
    tick();
    checks++;
    if (rsp_valid !== 1'b1 || rsp_id !== 2'd2 || rsp_sum !== op_a[2] + op_b[2]) begin
      errors++;
      $display("[TB] FAIL bp_second_rsp: got v=%b id=%0d sum=%h expected 1/2/%h", rsp_valid, rsp_id, rsp_sum, op_a[2] + op_b[2]);
    end
    tick();
  endtask

  task automatic test_reset_mid;
    do_reset();
    for (int i = 0; i < NUM_REQ; i++) begin
      op_a[i[ID_W-1:0]] = $urandom;
      op_b[i[ID_W-1:0]] = $urandom;
    end
    req_valid = '1;
    rsp_ready = 1'b1;
    #1;
    m_last = 0;
    tick();
    req_valid = 4'b0110;
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (req_ready !== '0 || add_in1 !== 32'h0 || add_in2 !== 32'h0 ||
        rsp_valid !== 1'b0 || rsp_id !== '0 || rsp_sum !== 32'h0) begin
      errors++;
      $display("[TB] FAIL midrst_clear: got ready=%b in=%h/%h v=%b id=%0d sum=%h expected all 0",
               req_ready, add_in1, add_in2, rsp_valid, rsp_id, rsp_sum);
    end
    req_valid = '0;
    tick();
    tick();
    rst_n  = 1'b1;
    m_last = NUM_REQ - 1;
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++;
      if (rsp_valid !== 1'b0) begin
        errors++;
        $display("[TB] FAIL midrst_stale%0d: got %b expected 0", c, rsp_valid);
      end
    end
    req_valid = 4'b1101;
    #1;
    checks++;
    if (req_ready !== 4'b0001) begin
      errors++;
      $display("[TB] FAIL midrst_regrant: got %b expected 0001", req_ready);
    end
    m_last = 0;
    tick();
    req_valid = '0;
    tick();
    checks++;
    if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_sum !== op_a[0] + op_b[0]) begin
      errors++;
      $display("[TB] FAIL midrst_rsp: got v=%b id=%0d sum=%h expected 1/0/%h", rsp_valid, rsp_id, rsp_sum, op_a[0] + op_b[0]);
    end
    tick();
  endtask

  task automatic test_sparse;
    int g;
    do_reset();
    for (int i = 0; i < NUM_REQ; i++) begin
      op_a[i[ID_W-1:0]] = $urandom;
      op_b[i[ID_W-1:0]] = $urandom;
    end
    req_valid = 4'b1010;
    rsp_ready = 1'b1;
    #1;
    for (int t = 0; t < 4; t++) begin
      g = (t % 2 == 0) ? 1 : 3;
      checks++;
      if (req_ready !== onehot(g)) begin
        errors++;
        $display("[TB] FAIL sparse_grant%0d: got %b expected %b", t, req_ready, onehot(g));
      end
      m_last = g;
      tick();
      checks++;
      if (req_ready !== '0) begin
        errors++;
        $display("[TB] FAIL sparse_exec_ready%0d: got %b expected 0000", t, req_ready);
      end
      tick();
      checks++;
      if (rsp_valid !== 1'b1 || int'(rsp_id) != g || rsp_sum !== op_a[g[ID_W-1:0]] + op_b[g[ID_W-1:0]]) begin
        errors++;
        $display("[TB] FAIL sparse_rsp%0d: got v=%b id=%0d sum=%h expected 1/%0d/%h", t, rsp_valid, rsp_id, rsp_sum, g,
                 op_a[g[ID_W-1:0]] + op_b[g[ID_W-1:0]]);
      end
      tick();
    end
    req_valid = '0;
    #1;
  endtask

  // Scoreboard run: random arrivals, withdrawals and backpressure; the block is idle exactly when nothing is outstanding
  task automatic test_random;
    exp_t q[$];
    exp_t ex;
    exp_t got;
    int pick;
    int granted;
    logic [NUM_REQ-1:0] exp_ready;
    do_reset();
    for (int cyc = 0; cyc < 600; cyc++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!req_valid[i] && $urandom_range(0, 3) == 0) begin
          case ($urandom_range(0, 3))
            0: op_a[i[ID_W-1:0]] = 32'hFFFF_FFFF;
            1: op_a[i[ID_W-1:0]] = 32'h7FFF_FFFF;
            default: op_a[i[ID_W-1:0]] = $urandom;
          endcase
          op_b[i[ID_W-1:0]] = ($urandom_range(0, 3) == 0) ? 32'h0000_0001 : $urandom;
          req_valid[i] = 1'b1;
        end else if (req_valid[i] && $urandom_range(0, 15) == 0) begin
          req_valid[i] = 1'b0;
        end
      end
      rsp_ready = ($urandom_range(0, 2) != 0);
      #1;
      pick = model_pick(req_valid);
      exp_ready = (q.size() == 0) ? onehot(pick) : '0;
      checks++;
      if (req_ready !== exp_ready) begin
        errors++;
        $display("[TB] FAIL rand_ready c%0d: got %b expected %b", cyc, req_ready, exp_ready);
      end
      granted = -1;
      if (rsp_valid === 1'b1 && rsp_ready) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("[TB] FAIL rand_unexpected_rsp c%0d: got id=%0d sum=%h expected none", cyc, rsp_id, rsp_sum);
        end else begin
          ex  = q.pop_front();
          got.id  = int'(rsp_id);
          got.sum = rsp_sum;
`ifdef ADDER_ARB_OVF_EN
          got.ovf = rsp_ovf;
`else
          got.ovf = ex.ovf;
`endif
          if (got.id != ex.id || got.sum !== ex.sum || got.ovf !== ex.ovf) begin
            errors++;
            $display("[TB] FAIL rand_rsp c%0d: got id=%0d sum=%h ovf=%b expected %0d/%h/%b",
                     cyc, got.id, got.sum, got.ovf, ex.id, ex.sum, ex.ovf);
          end
        end
      end else if (q.size() == 0 && pick >= 0) begin
        ex.id  = pick;
        ex.sum = op_a[pick[ID_W-1:0]] + op_b[pick[ID_W-1:0]];
        ex.ovf = model_ovf(op_a[pick[ID_W-1:0]], op_b[pick[ID_W-1:0]]);
        q.push_back(ex);
        m_last  = pick;
        granted = pick;
      end
      tick();
      if (granted >= 0) req_valid[granted[ID_W-1:0]] = 1'b0;
    end
    req_valid = '0;
    rsp_ready = 1'b1;
    for (int c = 0; c < 6 && q.size() != 0; c++) begin
      #1;
      if (rsp_valid === 1'b1) begin
        ex = q.pop_front();
        checks++;
        if (int'(rsp_id) != ex.id || rsp_sum !== ex.sum) begin
          errors++;
          $display("[TB] FAIL rand_drain: got id=%0d sum=%h expected %0d/%h", rsp_id, rsp_sum, ex.id, ex.sum);
        end
      end
      tick();
    end
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("[TB] FAIL rand_outstanding: got %0d pending expected 0", q.size());
    end
  endtask

  initial begin
    $display("[TB] adder_share_arbiter bench start");
    test_reset();
    test_single();
    test_wrap();
    test_round_robin();
    test_backpressure();
    test_reset_mid();
    test_sparse();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/adder_share_arbiter.md
Name: adder_share_arbiter

Overview:
- Shares one external combinational 32-bit adder among NUM_REQ requesters, e.g. PC+4, branch target and address generation in the 5-stage MIPS datapath.
- Grants requesters round-robin and latches the selected operands.
- Drives the adder, registers its sum, and returns it with the requester's ID over a valid/ready response channel.
- Allows one transaction in flight at a time.

Parameters:
- NUM_REQ, 4, number of requesters; legal range 2..8.
- ID_W, 2, width of the requester index; must equal ceil(log2(NUM_REQ)).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  NUM_REQ  per-requester request valid.
- req_ready  output  NUM_REQ  per-requester accept; at most one bit high.
- req_a  input  32*NUM_REQ  packed operand A; requester i occupies bits [32*i+31:32*i].
- req_b  input  32*NUM_REQ  packed operand B, same packing as req_a.
- add_in1  output  32  operand 1 to the external adder.
- add_in2  output  32  operand 2 to the external adder.
- add_sum  input  32  combinational sum returned by the external adder.
- rsp_valid  output  1  result valid.
- rsp_ready  input  1  consumer accepts the result.
- rsp_id  output  ID_W  index of the requester that owns the result.
- rsp_sum  output  32  registered sum.

Behaviour:
- FSM states: IDLE, EXEC, RESP. Reset state is IDLE.
- Values on reset:
  - req_ready = 0.
  - add_in1 = add_in2 = 0.
  - rsp_valid = 0, rsp_id = 0, rsp_sum = 0.
  - Internal last_grant = NUM_REQ-1, so requester 0 has first priority after reset.
- IDLE:
  - If any req_valid bit is set, select g = the first set bit scanning upward from last_grant+1, wrapping modulo NUM_REQ.
  - req_ready[g] = 1 combinationally in that same cycle. The handshake completes on that edge.
  - On that edge: latch a = req_a[g], b = req_b[g] and id = g; set last_grant = g; go to EXEC.
  - If no req_valid bit is set, stay in IDLE with req_ready = 0.
- EXEC (one cycle):
  - add_in1 = latched a, add_in2 = latched b.
  - At the edge: rsp_sum <= add_sum, rsp_id <= id, rsp_valid <= 1; go to RESP.
  - req_ready = 0.
- RESP:
  - rsp_valid, rsp_sum and rsp_id are held stable until a cycle with rsp_ready = 1.
  - On that edge: rsp_valid <= 0; go to IDLE.
  - req_ready = 0 throughout RESP.
- add_in1 and add_in2 keep their last values outside EXEC (no glitching to 0), which lowers toggle activity.
- Latency:
  - The accept edge is T0; rsp_valid is seen high in cycle T0+2.
  - Minimum transaction period is 3 cycles when rsp_ready is held high.
- Arithmetic: modulo 2^32. Carry out is discarded, e.g. 0xFFFFFFFF + 0x00000001 = 0x00000000.
- Requester side:
  - A requester must hold req_valid, req_a and req_b stable until it sees req_ready.
  - Deasserting req_valid before grant is permitted; the block simply skips that requester.
- Simultaneous events:
  - rsp_ready is ignored outside RESP.
  - New requests arriving during EXEC or RESP wait for IDLE.
- Fairness: round-robin guarantees that any requester holding valid is granted within NUM_REQ transactions.
- Reset mid-operation:
  - Asserting rst_n low forces IDLE immediately and clears all outputs.
  - The in-flight result is lost, and no response is produced for it after reset is released.
- rsp_id always matches the requester whose operands produced rsp_sum.

Optional Feature:
- Macro: ADDER_ARB_OVF_EN.
- When defined:
  - Adds output port rsp_ovf (1 bit), captured in EXEC alongside rsp_sum.
  - rsp_ovf = (a[31] == b[31]) && (add_sum[31] != a[31]), i.e. signed overflow for MIPS add/addi trap detection.
  - rsp_ovf resets to 0 and is held with rsp_sum while in RESP.
- When undefined: the port and its register are absent, and behaviour is otherwise identical.

Test Plan:
- Single request: requester 0 sends a=0x00000005, b=0x00000003 with rsp_ready=1.
  - req_ready[0] is high in the accept cycle.
  - Two cycles later: rsp_valid=1, rsp_sum=0x00000008, rsp_id=0.
- Wrap-around: a=0xFFFFFFFF, b=0x00000001.
  - rsp_sum=0x00000000.
  - With ADDER_ARB_OVF_EN: rsp_ovf=0. With a=0x7FFFFFFF, b=1: rsp_sum=0x80000000 and rsp_ovf=1.
- Round-robin: all four requesters held valid continuously, each with a distinct b = id.
  - Grant order after reset is 0,1,2,3,0.
  - rsp_id sequence matches, and each sum is correct.
- Backpressure: hold rsp_ready=0 for 5 cycles after rsp_valid rises.
  - rsp_valid, rsp_sum and rsp_id stay stable, and no req_ready pulses.
  - The next grant occurs in the first IDLE cycle after rsp_ready=1.
- Reset mid-operation: assert rst_n=0 during EXEC.
  - All outputs are 0 asynchronously; after release no stale response appears.
  - The next grant goes to the lowest valid requester (requester 0 if valid).
- Sparse requests: only requesters 1 and 3 are valid.
  - Grants alternate 1,3,1,3.
  - Requesters 0 and 2 are never acknowledged.
